ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/mdu_iter_core.sv | 115 +++++++++++
 rtl/ex_muldiv_unit.sv | 120 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Purpose: shared constants and types for the M-extension multiply/divide unit.
//   XLEN/ITER    : datapath width and iteration count
//   OP_*         : ALU_OP encodings of the eight M-extension ops
//   state_e      : control FSM states
package muldiv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = $clog2(ITER);
   localparam int unsigned OP_W  = 5;
   localparam int unsigned RD_W  = 5;

   localparam logic [OP_W-1:0] OP_MUL    = 5'h10;
   localparam logic [OP_W-1:0] OP_MULH   = 5'h11;
   localparam logic [OP_W-1:0] OP_MULHSU = 5'h12;
   localparam logic [OP_W-1:0] OP_MULHU  = 5'h13;
   localparam logic [OP_W-1:0] OP_DIV    = 5'h14;
   localparam logic [OP_W-1:0] OP_DIVU   = 5'h15;
   localparam logic [OP_W-1:0] OP_REM    = 5'h16;
   localparam logic [OP_W-1:0] OP_REMU   = 5'h17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // True for any op in the M-extension group (ALU_OP[4:3] == 2'b10).
   function automatic logic is_md_op(input logic [OP_W-1:0] op);
      return op[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Purpose: iterative multiply/divide datapath, one radix-2 step per i_step.
//   i_load     : latch op, operand magnitudes and result sign
//   i_step     : perform one shift-add (mul) or restoring shift-subtract (div) step
//   i_func     : low three bits of the op code
//   i_data1/2  : rs1 / rs2 operands
//   o_result_c : signed-corrected result as it will be after the current step
module mdu_iter_core
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [2:0]      i_func,
   input  logic [XLEN-1:0] i_data1,
   input  logic [XLEN-1:0] i_data2,
   output logic [XLEN-1:0] o_result_c
);

   logic [2:0]        r_func;
   logic              r_neg;
   logic [XLEN-1:0]   r_hi;     // product high half / partial remainder
   logic [XLEN-1:0]   r_lo;     // multiplier, product low half / dividend -> quotient
   logic [XLEN-1:0]   r_opnd;   // multiplicand / divisor magnitude

   logic              w_sgn1;
   logic              w_sgn2;
   logic              w_div0;
   logic              w_load_neg;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic [XLEN-1:0]   w_hi_nx;
   logic [XLEN-1:0]   w_lo_nx;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_dres;
   logic [XLEN-1:0]   w_dres_s;

   // Operand signs, magnitudes and the sign to apply to the final result.
   always_comb begin
      w_sgn1 = 1'b0;
      w_sgn2 = 1'b0;
      case (i_func)
         OP_MUL[2:0], OP_MULH[2:0], OP_DIV[2:0], OP_REM[2:0]: begin
            w_sgn1 = i_data1[XLEN-1];
            w_sgn2 = i_data2[XLEN-1];
         end
         OP_MULHSU[2:0]: w_sgn1 = i_data1[XLEN-1];
         default: ;
      endcase
      w_mag1 = w_sgn1 ? (~i_data1 + XLEN'(1)) : i_data1;
      w_mag2 = w_sgn2 ? (~i_data2 + XLEN'(1)) : i_data2;
      w_div0 = (i_data2 == '0);
      // Divide-by-zero quotient stays all-ones; remainder follows the dividend sign.
      if (i_func[2])
         w_load_neg = i_func[1] ? w_sgn1 : ((w_sgn1 ^ w_sgn2) & ~w_div0);
      else
         w_load_neg = w_sgn1 ^ w_sgn2;
   end

   // One iteration step and the corrected result it would produce.
   always_comb begin
      w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opnd}) : {1'b0, r_hi};
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_opnd};
      if (r_func[2]) begin
         if (!w_diff[XLEN]) begin
            w_hi_nx = w_diff[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
         end else begin
            w_hi_nx = w_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         w_hi_nx = w_sum[XLEN:1];
         w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end

      w_prod   = {w_hi_nx, w_lo_nx};
      w_prod_s = r_neg ? (~w_prod + (2*XLEN)'(1)) : w_prod;
      w_dres   = r_func[1] ? w_hi_nx : w_lo_nx;
      w_dres_s = r_neg ? (~w_dres + XLEN'(1)) : w_dres;

      if (r_func[2])
         o_result_c = w_dres_s;
      else if (r_func == OP_MUL[2:0])
         o_result_c = w_prod_s[XLEN-1:0];
      else
         o_result_c = w_prod_s[2*XLEN-1:XLEN];
   end

   // Datapath registers: load on acceptance, advance one step per i_step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_func <= '0;
         r_neg  <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opnd <= '0;
      end else if (i_load) begin
         r_func <= i_func;
         r_neg  <= w_load_neg;
         r_hi   <= '0;
         r_lo   <= i_func[2] ? w_mag1 : w_mag2;
         r_opnd <= i_func[2] ? w_mag2 : w_mag1;
      end else if (i_step) begin
         r_hi   <= w_hi_nx;
         r_lo   <= w_lo_nx;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Purpose: EX-stage multi-cycle multiply/divide unit with pipeline stall handshake.
//   CLK, RESET_N         : clock, async active-low reset
//   START, IN_ALU_OP     : ID/EX holds an op; op code selects the M-extension function
//   IN_DATA1, IN_DATA2   : rs1 / rs2 operands
//   IN_RD                : destination register of the op
//   FLUSH                : kill request, aborts any operation in flight
//   BUSY                 : stall request to PC, IF/ID and ID/EX
//   OUT_VALID            : one-cycle result strobe (DONE state)
//   OUT_RESULT, OUT_RD   : result and its destination, held between results
module ex_muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic [4:0]      IN_ALU_OP,
   input  logic [31:0]     IN_DATA1,
   input  logic [31:0]     IN_DATA2,
   input  logic [4:0]      IN_RD,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            OUT_VALID,
   output logic [31:0]     OUT_RESULT,
   output logic [4:0]      OUT_RD
);

   state_e            r_state;
   state_e            w_state_nx;
   logic [CNT_W-1:0]  r_cnt;
   logic [RD_W-1:0]   r_rd;
   logic [XLEN-1:0]   r_out_result;
   logic [RD_W-1:0]   r_out_rd;

   logic              w_op_valid;
   logic              w_accept;
   logic              w_step;
   logic              w_finish;
   logic [XLEN-1:0]   w_result_c;

   assign w_op_valid = is_md_op(IN_ALU_OP);

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= IDLE;
      else          r_state <= w_state_nx;
   end

   // Next state and datapath controls; START is ignored outside IDLE.
   always_comb begin
      w_state_nx = r_state;
      w_accept   = 1'b0;
      w_step     = 1'b0;
      w_finish   = 1'b0;
      case (r_state)
         IDLE: begin
            if (START && w_op_valid && !FLUSH) begin
               w_state_nx = CALC;
               w_accept   = 1'b1;
            end
         end
         CALC: begin
            if (FLUSH) begin
               w_state_nx = IDLE;
            end else begin
               w_step = 1'b1;
               if (r_cnt == CNT_W'(ITER - 1)) begin
                  w_state_nx = DONE;
                  w_finish   = 1'b1;
               end
            end
         end
         DONE:    w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Handshake outputs follow the state and live inputs; both forced low in reset.
   assign BUSY      = RESET_N & (((r_state == IDLE) & START & w_op_valid & ~FLUSH) |
                                 (r_state == CALC));
   assign OUT_VALID = RESET_N & (r_state == DONE) & ~FLUSH;

   // Iteration counter and latched destination register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt <= '0;
         r_rd  <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_rd  <= IN_RD;
      end else if (w_step) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Result registers load only on the final step so they hold until the next result.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_out_result <= '0;
         r_out_rd     <= '0;
      end else if (w_finish) begin
         r_out_result <= w_result_c;
         r_out_rd     <= r_rd;
      end
   end

   assign OUT_RESULT = r_out_result;
   assign OUT_RD     = r_out_rd;

   mdu_iter_core u_core (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .i_load     (w_accept),
      .i_step     (w_step),
      .i_func     (IN_ALU_OP[2:0]),
      .i_data1    (IN_DATA1),
      .i_data2    (IN_DATA2),
      .o_result_c (w_result_c)
   );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed vector table plus abort/back-to-back sequences.
module tb_ex_muldiv_unit;
   import muldiv_pkg::*;

   logic        CLK;
   logic        RESET_N;
   logic        START;
   logic [4:0]  IN_ALU_OP;
   logic [31:0] IN_DATA1;
   logic [31:0] IN_DATA2;
   logic [4:0]  IN_RD;
   logic        FLUSH;
   logic        BUSY;
   logic        OUT_VALID;
   logic [31:0] OUT_RESULT;
   logic [4:0]  OUT_RD;

   int n_pass;
   int n_total;

   ex_muldiv_unit dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .START      (START),
      .IN_ALU_OP  (IN_ALU_OP),
      .IN_DATA1   (IN_DATA1),
      .IN_DATA2   (IN_DATA2),
      .IN_RD      (IN_RD),
      .FLUSH      (FLUSH),
      .BUSY       (BUSY),
      .OUT_VALID  (OUT_VALID),
      .OUT_RESULT (OUT_RESULT),
      .OUT_RD     (OUT_RD)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issue one op from IDLE; START drops after the accepting edge.
   // Cycle e is the cycle ending at edge e (edge 0 samples START).
   task automatic run_op(input vec_t v, input string tag);
      int busy_cnt;
      int valid_cnt;
      int valid_at;
      logic [31:0] res;
      logic [4:0]  rdo;
      busy_cnt  = 0;
      valid_cnt = 0;
      valid_at  = -1;
      res       = '0;
      rdo       = '0;
      START     = 1'b1;
      IN_ALU_OP = v.op;
      IN_DATA1  = v.a;
      IN_DATA2  = v.b;
      IN_RD     = v.rd;
      for (int e = 0; e < 40; e++) begin
         #1;
         if (BUSY) busy_cnt++;
         if (OUT_VALID) begin
            valid_cnt++;
            valid_at = e;
            res = OUT_RESULT;
            rdo = OUT_RD;
         end
         tick();
         if (e == 0) START = 1'b0;
      end
      chk({tag, " result"}, res, v.exp);
      chk({tag, " rd"}, 32'(rdo), 32'(v.rd));
      chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
      chk({tag, " valid_pulses"}, 32'(valid_cnt), 32'd1);
      chk({tag, " valid_edge"}, 32'(valid_at), 32'd33);
      chk({tag, " result_held"}, OUT_RESULT, v.exp);
   endtask

   vec_t v;
   int   cnt;
   int   vidx [2];
   logic [31:0] vres [2];
   logic [4:0]  vrd  [2];
   int   instr;
   logic adv;

   initial begin
      n_pass  = 0;
      n_total = 0;

      vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB};
      vecs[1]  = '{OP_MULH,   32'h80000000,   32'h80000000, 5'd1,  32'h40000000};
      vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE};
      vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD};
      vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF};
      vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,        5'd7,  32'd14};
      vecs[7]  = '{OP_REMU,   32'd100,        32'd7,        5'd8,  32'd2};
      vecs[8]  = '{OP_DIV,    32'd5,          32'd0,        5'd9,  32'hFFFFFFFF};
      vecs[9]  = '{OP_REM,    32'd5,          32'd0,        5'd10, 32'd5};
      vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000};
      vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 5'd12, 32'd0};
      vecs[12] = '{OP_MUL,    32'h12345678,   32'h00000010, 5'd31, 32'h23456780};
      vecs[13] = '{OP_REM,    32'hFFFFFFFB,   32'd0,        5'd13, 32'hFFFFFFFB};
      vecs[14] = '{OP_DIV,    32'hFFFFFFFB,   32'd0,        5'd14, 32'hFFFFFFFF};
      vecs[15] = '{OP_MULHU,  32'h80000000,   32'd2,        5'd15, 32'd1};

      // Reset with a valid START pending: everything must read zero.
      RESET_N   = 1'b0;
      START     = 1'b1;
      IN_ALU_OP = OP_MUL;
      IN_DATA1  = 32'd3;
      IN_DATA2  = 32'd4;
      IN_RD     = 5'd7;
      FLUSH     = 1'b0;
      #12;
      chk("reset busy",   32'(BUSY),      32'd0);
      chk("reset valid",  32'(OUT_VALID), 32'd0);
      chk("reset result", OUT_RESULT,     32'd0);
      chk("reset rd",     32'(OUT_RD),    32'd0);
      START = 1'b0;
      tick();
      RESET_N = 1'b1;
      tick();

      for (int i = 0; i < NVEC; i++)
         run_op(vecs[i], $sformatf("vec%0d", i));

      // Non-M op with START: ignored, no stall, no result.
      START     = 1'b1;
      IN_ALU_OP = 5'h00;
      cnt = 0;
      for (int e = 0; e < 40; e++) begin
         #1;
         if (BUSY || OUT_VALID) cnt++;
         tick();
      end
      START = 1'b0;
      chk("nonmd ignored", 32'(cnt), 32'd0);
      chk("nonmd result_held", OUT_RESULT, vecs[NVEC-1].exp);

      // FLUSH on the 10th CALC cycle.
      START     = 1'b1;
      IN_ALU_OP = OP_DIVU;
      IN_DATA1  = 32'd100;
      IN_DATA2  = 32'd7;
      IN_RD     = 5'd20;
      tick();                      // edge 0 accepts
      START = 1'b0;
      for (int e = 1; e < 10; e++) tick();
      FLUSH = 1'b1;                // during the 10th CALC cycle
      #1;
      chk("flush busy_in_calc", 32'(BUSY), 32'd1);
      tick();
      FLUSH = 1'b0;
      #1;
      chk("flush busy_after", 32'(BUSY), 32'd0);
      cnt = 0;
      for (int e = 0; e < 40; e++) begin
         if (OUT_VALID || BUSY) cnt++;
         tick();
      end
      chk("flush no_valid", 32'(cnt), 32'd0);
      chk("flush result_held", OUT_RESULT, vecs[NVEC-1].exp);
      chk("flush rd_held", 32'(OUT_RD), 32'(vecs[NVEC-1].rd));
      run_op(vecs[6], "after_flush");

      // Reset asserted mid-CALC.
      START     = 1'b1;
      IN_ALU_OP = OP_MUL;
      IN_DATA1  = 32'd9;
      IN_DATA2  = 32'd9;
      IN_RD     = 5'd21;
      tick();
      for (int e = 0; e < 6; e++) tick();
      RESET_N = 1'b0;              // START still high with a valid op
      #1;
      chk("midreset busy",   32'(BUSY),      32'd0);
      chk("midreset valid",  32'(OUT_VALID), 32'd0);
      chk("midreset result", OUT_RESULT,     32'd0);
      chk("midreset rd",     32'(OUT_RD),    32'd0);
      START = 1'b0;
      tick();
      RESET_N = 1'b1;
      cnt = 0;
      for (int e = 0; e < 40; e++) begin
         #1;
         if (OUT_VALID || BUSY) cnt++;
         tick();
      end
      chk("midreset aborted", 32'(cnt), 32'd0);

      // Back-to-back DIVU then MUL; START stays high through DONE.
      // ID/EX advances on an edge where BUSY was low.
      instr = 0;
      cnt   = 0;
      START     = 1'b1;
      IN_ALU_OP = OP_DIVU;
      IN_DATA1  = 32'd100;
      IN_DATA2  = 32'd7;
      IN_RD     = 5'd3;
      for (int e = 0; e < 100; e++) begin
         #1;
         adv = !BUSY;
         if (OUT_VALID) begin
            if (cnt < 2) begin
               vidx[cnt] = e;
               vres[cnt] = OUT_RESULT;
               vrd[cnt]  = OUT_RD;
            end
            cnt++;
         end
         tick();
         if (adv && START) begin
            instr++;
            if (instr == 1) begin
               IN_ALU_OP = OP_MUL;
               IN_DATA1  = 32'd7;
               IN_DATA2  = 32'hFFFFFFFD;
               IN_RD     = 5'd9;
            end else begin
               START = 1'b0;
            end
         end
      end
      START = 1'b0;
      chk("b2b pulses", 32'(cnt), 32'd2);
      if (cnt >= 2) begin
         chk("b2b first_edge",   32'(vidx[0]), 32'd33);
         chk("b2b first_result", vres[0],      32'd14);
         chk("b2b first_rd",     32'(vrd[0]),  32'd3);
         chk("b2b second_edge",  32'(vidx[1]), 32'd67);
         chk("b2b second_result", vres[1],     32'hFFFFFFEB);
         chk("b2b second_rd",    32'(vrd[1]),  32'd9);
      end else begin
         chk("b2b pulses_seen", 32'(cnt), 32'd2);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
